// File: rtl/dsc_mul_ctrl.sv
// Run controller wrapped around the 4-input deterministic stochastic
// multiplier core. It takes one operand set, clears and runs the core until
// its early-shutoff flag (or a cycle limit) ends the run, then presents the
// captured count through a valid/ready output.
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | ready for an operand set; core held cleared
// CLEAR | one-cycle clear of the core with the new operands applied
// RUN   | core enabled; cycle counter advancing; watching mul_ov/limit
// DRAIN | core disabled for one cycle so its count settles, then capture
// DONE  | result presented on out_*; waits for out_ready
module dsc_mul_ctrl #(
  parameter int SNG_WIDTH  = 6,
  parameter int NUM_INPUTS = 4,
  parameter int MIN_RUN    = 2,
  parameter int MAX_CYCLES = 2**(NUM_INPUTS*SNG_WIDTH) + 4,
  parameter int CYC_W      = NUM_INPUTS*SNG_WIDTH + 2
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            in_valid,
  output logic                            in_ready,
  input  logic [SNG_WIDTH-1:0]            in_a,
  input  logic [SNG_WIDTH-1:0]            in_b,
  input  logic [SNG_WIDTH-1:0]            in_c,
  input  logic [SNG_WIDTH-1:0]            in_d,
  output logic [SNG_WIDTH-1:0]            mul_a,
  output logic [SNG_WIDTH-1:0]            mul_b,
  output logic [SNG_WIDTH-1:0]            mul_c,
  output logic [SNG_WIDTH-1:0]            mul_d,
  output logic                            mul_rst,
  output logic                            mul_en,
  input  logic [NUM_INPUTS*SNG_WIDTH-1:0] mul_z,
  input  logic                            mul_ov,
  output logic                            out_valid,
  input  logic                            out_ready,
  output logic [NUM_INPUTS*SNG_WIDTH-1:0] out_z,
  output logic [CYC_W-1:0]                out_cycles,
  output logic                            out_timeout
);

  localparam int ZW = NUM_INPUTS*SNG_WIDTH;
  localparam logic [CYC_W-1:0] MIN_RUN_C = CYC_W'(MIN_RUN);
  localparam logic [CYC_W-1:0] CNT_LAST  = CYC_W'(MAX_CYCLES - 1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    CLEAR = 3'd1,
    RUN   = 3'd2,
    DRAIN = 3'd3,
    DONE  = 3'd4
  } state_t;

  state_t               state, state_n;
  logic [CYC_W-1:0]     cnt, cnt_n;
  logic [SNG_WIDTH-1:0] mul_a_n, mul_b_n, mul_c_n, mul_d_n;
  logic [ZW-1:0]        out_z_n;
  logic [CYC_W-1:0]     out_cycles_n;
  logic                 out_timeout_n;
  logic                 any_zero;
  logic                 ov_hit;
  logic                 limit_hit;

  // Exit conditions for RUN; mul_ov is masked until the core's SNGs settle.
  always_comb begin
    any_zero  = (in_a == '0) || (in_b == '0) || (in_c == '0) || (in_d == '0);
    ov_hit    = mul_ov && (cnt >= MIN_RUN_C);
    limit_hit = (cnt == CNT_LAST);
  end

  // Next-state and next-datapath values; everything holds by default.
  always_comb begin
    state_n       = state;
    cnt_n         = cnt;
    mul_a_n       = mul_a;
    mul_b_n       = mul_b;
    mul_c_n       = mul_c;
    mul_d_n       = mul_d;
    out_z_n       = out_z;
    out_cycles_n  = out_cycles;
    out_timeout_n = out_timeout;
    case (state)
      IDLE: begin
        if (in_valid && in_ready) begin
          mul_a_n = in_a;
          mul_b_n = in_b;
          mul_c_n = in_c;
          mul_d_n = in_d;
          cnt_n   = '0;
          if (any_zero) begin
            // A zero operand makes the product zero; skip running the core.
            out_z_n       = '0;
            out_cycles_n  = '0;
            out_timeout_n = 1'b0;
            state_n       = DONE;
          end else begin
            state_n = CLEAR;
          end
        end
      end
      CLEAR: begin
        state_n = RUN;
      end
      RUN: begin
        if (cnt != CNT_LAST) begin
          cnt_n = cnt + 1'b1;
        end
        // mul_ov takes priority when it coincides with the cycle limit.
        if (ov_hit) begin
          out_timeout_n = 1'b0;
          state_n       = DRAIN;
        end else if (limit_hit) begin
          out_timeout_n = 1'b1;
          state_n       = DRAIN;
        end
      end
      DRAIN: begin
        out_z_n      = mul_z;
        out_cycles_n = cnt;
        state_n      = DONE;
      end
      DONE: begin
        if (out_valid && out_ready) begin
          state_n = IDLE;
        end
      end
      default: begin
        state_n = IDLE;
      end
    endcase
  end

  // State, datapath and registered handshake/core controls decoded from
  // the next state so every output comes straight from a flop.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      cnt         <= '0;
      mul_a       <= '0;
      mul_b       <= '0;
      mul_c       <= '0;
      mul_d       <= '0;
      out_z       <= '0;
      out_cycles  <= '0;
      out_timeout <= 1'b0;
      in_ready    <= 1'b1;
      out_valid   <= 1'b0;
      mul_rst     <= 1'b1;
      mul_en      <= 1'b0;
    end else begin
      state       <= state_n;
      cnt         <= cnt_n;
      mul_a       <= mul_a_n;
      mul_b       <= mul_b_n;
      mul_c       <= mul_c_n;
      mul_d       <= mul_d_n;
      out_z       <= out_z_n;
      out_cycles  <= out_cycles_n;
      out_timeout <= out_timeout_n;
      in_ready    <= (state_n == IDLE);
      out_valid   <= (state_n == DONE);
      mul_rst     <= (state_n == IDLE) || (state_n == CLEAR);
      mul_en      <= (state_n == RUN);
    end
  end

endmodule

// File: tb/tb_dsc_mul_ctrl.sv
// Directed bench for dsc_mul_ctrl with a small behavioural stand-in for the
// multiplier core: z counts enabled cycles, and mul_ov is either tied low,
// tied high, or rises once the core has seen ov_at enabled cycles.
module tb_dsc_mul_ctrl;

  localparam int SW  = 6;
  localparam int NI  = 4;
  localparam int ZW  = SW*NI;
  localparam int CW  = ZW + 2;
  localparam int MAX = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [SW-1:0] in_a, in_b, in_c, in_d;
  logic [SW-1:0] mul_a, mul_b, mul_c, mul_d;
  logic          mul_rst, mul_en;
  logic [ZW-1:0] mul_z;
  logic          mul_ov;
  logic          out_valid, out_ready;
  logic [ZW-1:0] out_z;
  logic [CW-1:0] out_cycles;
  logic          out_timeout;

  int total = 0;
  int bad   = 0;

  int ov_mode = 0;
  int ov_at   = 0;
  int core_k;
  logic [ZW-1:0] core_z;

  dsc_mul_ctrl #(
    .SNG_WIDTH(SW), .NUM_INPUTS(NI), .MIN_RUN(2), .MAX_CYCLES(MAX), .CYC_W(CW)
  ) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_c(in_c), .in_d(in_d),
    .mul_a(mul_a), .mul_b(mul_b), .mul_c(mul_c), .mul_d(mul_d),
    .mul_rst(mul_rst), .mul_en(mul_en),
    .mul_z(mul_z), .mul_ov(mul_ov),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_z(out_z), .out_cycles(out_cycles), .out_timeout(out_timeout)
  );

  always #5 clk = ~clk;

  // Behavioural core: cleared by mul_rst, counts while enabled.
  always_ff @(posedge clk) begin
    if (mul_rst) begin
      core_z <= '0;
      core_k <= 0;
    end else if (mul_en) begin
      core_z <= core_z + 1'b1;
      core_k <= core_k + 1;
    end
  end

  assign mul_z  = core_z;
  assign mul_ov = (ov_mode == 1) || ((ov_mode == 2) && (core_k >= ov_at));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Offer one operand set and wait (bounded) for out_valid; lat counts
  // cycles from the accept cycle to the first out_valid cycle.
  task automatic run_op(input logic [SW-1:0] a, b, c, d,
                        output int lat, output int rst_hi, output int en_hi);
    @(negedge clk);
    in_a = a; in_b = b; in_c = c; in_d = d;
    in_valid = 1'b1;
    chk("accept_ready", in_ready, 1);
    @(negedge clk);
    in_valid = 1'b0;
    lat = 1; rst_hi = 0; en_hi = 0;
    while (!out_valid && lat < 200) begin
      if (mul_rst) rst_hi++;
      if (mul_en)  en_hi++;
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic take_result(input string tag);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk({tag, "_ready_after"}, in_ready, 1);
    chk({tag, "_valid_after"}, out_valid, 0);
  endtask

  int lat, rst_hi, en_hi, seen;
  logic [ZW-1:0] hz;
  logic [CW-1:0] hc;

  initial begin
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    in_a = '0; in_b = '0; in_c = '0; in_d = '0;
    repeat (3) @(negedge clk);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_mul_rst", mul_rst, 1);
    chk("rst_mul_en", mul_en, 0);
    chk("rst_out_z", out_z, 0);
    chk("rst_out_cycles", out_cycles, 0);
    chk("rst_out_timeout", out_timeout, 0);
    chk("rst_mul_a", mul_a, 0);
    rst = 1'b0;

    // Reset mid-RUN: accept, CLEAR, then RUN cycles 0..5.
    ov_mode = 0;
    @(negedge clk);
    in_a = 63; in_b = 63; in_c = 63; in_d = 63; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    chk("mid_clear_rst", mul_rst, 1);
    repeat (6) @(negedge clk);
    chk("mid_run_en", mul_en, 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("mid_rst_en", mul_en, 0);
    chk("mid_rst_mul_rst", mul_rst, 1);
    chk("mid_rst_valid", out_valid, 0);
    chk("mid_rst_ready", in_ready, 1);
    seen = 0;
    repeat (25) begin
      @(negedge clk);
      if (out_valid) seen++;
    end
    chk("mid_rst_no_valid", seen, 0);

    // Normal run: ov rises after 10 enabled cycles -> 11 RUN cycles.
    ov_mode = 2; ov_at = 10;
    run_op(63, 63, 63, 63, lat, rst_hi, en_hi);
    chk("norm_latency", lat, 14);
    chk("norm_clear_cycles", rst_hi, 1);
    chk("norm_en_cycles", en_hi, 11);
    chk("norm_out_z", out_z, 11);
    chk("norm_out_cycles", out_cycles, 11);
    chk("norm_timeout", out_timeout, 0);
    chk("norm_mul_d", mul_d, 63);
    take_result("norm");

    // Zero shortcut.
    run_op(0, 63, 63, 63, lat, rst_hi, en_hi);
    chk("zero_latency", lat, 1);
    chk("zero_en_cycles", en_hi, 0);
    chk("zero_en_now", mul_en, 0);
    chk("zero_out_z", out_z, 0);
    chk("zero_out_cycles", out_cycles, 0);
    chk("zero_timeout", out_timeout, 0);
    take_result("zero");

    // mul_ov high from the first RUN cycle is masked until counter==2.
    ov_mode = 1;
    run_op(5, 9, 17, 33, lat, rst_hi, en_hi);
    chk("mask_latency", lat, 6);
    chk("mask_out_cycles", out_cycles, 3);
    chk("mask_out_z", out_z, 3);
    chk("mask_timeout", out_timeout, 0);
    take_result("mask");

    // Timeout: ov never rises; 16 RUN cycles, counter saturates at 15.
    ov_mode = 0;
    run_op(1, 2, 3, 4, lat, rst_hi, en_hi);
    chk("to_latency", lat, 19);
    chk("to_out_cycles", out_cycles, 15);
    chk("to_out_z", out_z, 16);
    chk("to_timeout", out_timeout, 1);

    // Backpressure for 20 cycles in DONE.
    hz = out_z; hc = out_cycles;
    seen = 0;
    repeat (20) begin
      @(negedge clk);
      if (!out_valid || in_ready || out_z != 24'd16 || out_cycles != 26'd15 || !out_timeout) seen++;
    end
    chk("bp_stable_bad_cycles", seen, 0);
    chk("bp_hold_z", hz, 16);
    // Release with a back-to-back operand set already waiting.
    in_a = 7; in_b = 0; in_c = 9; in_d = 11; in_valid = 1'b1; out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk("b2b_ready", in_ready, 1);
    chk("b2b_valid_low", out_valid, 0);
    @(negedge clk);
    in_valid = 1'b0;
    chk("b2b_valid", out_valid, 1);
    chk("b2b_mul_a", mul_a, 7);
    chk("b2b_mul_d", mul_d, 11);
    chk("b2b_out_z", out_z, 0);
    chk("b2b_timeout", out_timeout, 0);
    take_result("b2b");

    // ov rising exactly at the limit cycle beats the timeout.
    ov_mode = 2; ov_at = 15;
    run_op(63, 1, 63, 1, lat, rst_hi, en_hi);
    chk("tie_latency", lat, 19);
    chk("tie_out_cycles", out_cycles, 15);
    chk("tie_timeout", out_timeout, 0);
    take_result("tie");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
